// File: rtl/bist_pkg.sv
// Shared types and constants for the lane-array built-in self-test engine.
package bist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int LANE_IN_W  = 4;
   localparam int LANE_OUT_W = 5;

   localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
   localparam logic [31:0] DEF_MISR_TAPS = 32'h04C11DB7;

endpackage

// File: rtl/bist_lane_cell.sv
// Combinational 4-in/5-out lane function; one instance per lane.
module bist_lane_cell
   import bist_pkg::*;
(
   input  logic [LANE_IN_W-1:0]  lane_i,
   output logic [LANE_OUT_W-1:0] lane_o
);

   logic a, b, c, d;

   assign {d, c, b, a} = lane_i;
   assign lane_o = {~d, b, a | c, c & d & ~a, a | d};

endmodule

// File: rtl/bist_lane_array.sv
// Self-testing lane array: LFSR patterns drive LANES lane cells, registered
// responses are compacted into a Galois MISR under a start/done/abort FSM.
module bist_lane_array
   import bist_pkg::*;
#(
   parameter int                 LANES     = 4,
   parameter int                 LFSR_W    = 16,
   parameter logic [LFSR_W-1:0]  LFSR_TAPS = DEF_LFSR_TAPS,
   parameter int                 MISR_W    = 32,
   parameter logic [MISR_W-1:0]  MISR_TAPS = DEF_MISR_TAPS,
   parameter int                 CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [LFSR_W-1:0]           seed,
   input  logic [CNT_W-1:0]            num_patterns,
   output logic                        busy,
   output logic                        done,
   output logic [MISR_W-1:0]           signature,
   output logic [LANE_OUT_W*LANES-1:0] resp,
   output logic                        resp_valid,
   output logic [CNT_W-1:0]            pat_count
);

   localparam int RESP_W = LANE_OUT_W * LANES;

   state_t              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d, seed_ld;
   logic [MISR_W-1:0]   misr_q, misr_d;
   logic [RESP_W-1:0]   resp_q, resp_d, lane_out;
   logic                vld_q, vld_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, num_q, num_d;
   logic                zero_q, zero_d;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
   endfunction

   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                   input logic [RESP_W-1:0] r);
      logic [MISR_W-1:0] ext;
      ext = '0;
      ext[RESP_W-1:0] = r;
      return (m << 1) ^ (m[MISR_W-1] ? MISR_TAPS : '0) ^ ext;
   endfunction

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      bist_lane_cell u_cell (
         .lane_i (lfsr_q[LANE_IN_W*i +: LANE_IN_W]),
         .lane_o (lane_out[LANE_OUT_W*i +: LANE_OUT_W])
      );
   end

   // A zero seed would lock the LFSR, so it is replaced by 1.
   assign seed_ld = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      resp_d  = resp_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      zero_d  = zero_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               lfsr_d = seed_ld;
               misr_d = '0;
               cnt_d  = '0;
               num_d  = num_patterns;
               vld_d  = 1'b0;
               if (num_patterns != '0) begin
                  state_d = RUN;
               end else begin
                  state_d = DONE;
                  zero_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end else begin
               if (vld_q) misr_d = misr_step(misr_q, resp_q);
               resp_d = lane_out;
               vld_d  = 1'b1;
               lfsr_d = lfsr_step(lfsr_q);
               cnt_d  = cnt_q + 1'b1;
               if (cnt_d == num_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!abort && vld_q) misr_d = misr_step(misr_q, resp_q);
            vld_d   = 1'b0;
            state_d = abort ? IDLE : DONE;
         end
         DONE: begin
            // An empty run spends one silent cycle here so its done pulse
            // lands one cycle after the start edge.
            if (zero_q) begin
               zero_d = 1'b0;
            end else begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= {{(LFSR_W-1){1'b0}}, 1'b1};
         misr_q  <= '0;
         resp_q  <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         num_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         resp_q  <= resp_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         zero_q  <= zero_d;
      end
   end

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign signature  = misr_q;
   assign resp       = resp_q;
   assign resp_valid = vld_q;
   assign pat_count  = cnt_q;

endmodule

// File: tb/tb_bist_lane_array.sv
// Bench for bist_lane_array: vector table of runs with a response scoreboard,
// plus reset-mid-run and abort sequences.
module tb_bist_lane_array;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] seed = '0;
   logic [15:0] num_patterns = '0;
   logic        busy, done, resp_valid;
   logic [31:0] signature;
   logic [19:0] resp;
   logic [15:0] pat_count;

   int errors = 0;
   int checks = 0;

   logic [19:0] exp_q[$];

   typedef struct {
      logic [15:0] seed;
      logic [15:0] n;
      logic [19:0] first;
      bit          chk_first;
      logic [31:0] sig;
      bit          chk_sig;
      bit          with_abort;
   } vec_t;

   vec_t tbl[4];

   always #5 clk = ~clk;

   bist_lane_array dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .seed         (seed),
      .num_patterns (num_patterns),
      .busy         (busy),
      .done         (done),
      .signature    (signature),
      .resp         (resp),
      .resp_valid   (resp_valid),
      .pat_count    (pat_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] lane_m(input logic [3:0] x);
      logic a, b, c, d;
      a = x[0]; b = x[1]; c = x[2]; d = x[3];
      return {~d, b, a | c, c & d & ~a, a | d};
   endfunction

   function automatic logic [19:0] resp_m(input logic [15:0] l);
      logic [19:0] r;
      for (int i = 0; i < 4; i++) r[5*i +: 5] = lane_m(l[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] lfsr_m(input logic [15:0] l);
      return {l[14:0], ^(l & 16'hB400)};
   endfunction

   function automatic logic [31:0] misr_m(input logic [31:0] m, input logic [19:0] r);
      return (m << 1) ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ {12'h000, r};
   endfunction

   // Signature after absorbing the first 'cnt' responses from 'sd';
   // optionally pushes those responses onto the scoreboard.
   function automatic logic [31:0] model_sig(input logic [15:0] sd, input int cnt, input bit push);
      logic [15:0] l;
      logic [31:0] m;
      logic [19:0] r;
      l = (sd == 16'h0) ? 16'h0001 : sd;
      m = '0;
      for (int i = 0; i < cnt; i++) begin
         r = resp_m(l);
         if (push) exp_q.push_back(r);
         m = misr_m(m, r);
         l = lfsr_m(l);
      end
      return m;
   endfunction

   task automatic run(input vec_t v, output logic [31:0] sig_out);
      logic [31:0] msig;
      logic [19:0] e, first_seen;
      int n, done_cnt, done_at, tim_bad, vld_cnt;
      n = int'(v.n);
      exp_q.delete();
      msig = model_sig(v.seed, n, 1'b1);
      done_cnt = 0; done_at = -1; tim_bad = 0; vld_cnt = 0; first_seen = '0;
      @(negedge clk);
      seed = v.seed; num_patterns = v.n; start = 1'b1; abort = v.with_abort;
      for (int k = 0; k <= n + 4; k++) begin
         @(negedge clk);
         if (busy !== (n > 0 && k <= n)) tim_bad++;
         if (resp_valid !== (k >= 1 && k <= n)) tim_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (resp_valid === 1'b1) begin
            if (vld_cnt == 0) first_seen = resp;
            vld_cnt++;
            if (exp_q.size() == 0) begin
               chk("resp_unexpected", {44'h0, resp}, 64'h0);
            end else begin
               e = exp_q.pop_front();
               chk("resp", {44'h0, resp}, {44'h0, e});
            end
         end
         start = 1'b0; abort = 1'b0;
         seed = 16'($urandom);
         num_patterns = 16'($urandom);
         // start is ignored while a run is in progress
         if (k == 2 && n >= 4) start = 1'b1;
      end
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("done_latency", 64'(done_at), (n == 0) ? 64'd1 : 64'(n + 1));
      chk("busy_valid_timing", 64'(tim_bad), 64'd0);
      chk("resp_count", 64'(vld_cnt), 64'(n));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("pat_count", {48'h0, pat_count}, {48'h0, v.n});
      chk("signature_model", {32'h0, signature}, {32'h0, msig});
      if (v.chk_sig) chk("signature_const", {32'h0, signature}, {32'h0, v.sig});
      if (v.chk_first) chk("first_resp", {44'h0, first_seen}, {44'h0, v.first});
      sig_out = signature;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
      chk({tag, "_done"}, {63'h0, done}, 64'h0);
      chk({tag, "_sig"}, {32'h0, signature}, 64'h0);
      chk({tag, "_resp"}, {44'h0, resp}, 64'h0);
      chk({tag, "_resp_valid"}, {63'h0, resp_valid}, 64'h0);
      chk({tag, "_pat_count"}, {48'h0, pat_count}, 64'h0);
   endtask

   initial begin
      logic [31:0] s_a, s_b, s_tmp, s_frozen, s_part;
      vec_t v;
      int waited, bad;

      tbl[0] = '{16'h000D, 16'd1, 20'h84205, 1'b1, 32'h00084205, 1'b1, 1'b0};
      tbl[1] = '{16'h1000, 16'd1, 20'hAC210, 1'b1, 32'h000AC210, 1'b1, 1'b0};
      tbl[2] = '{16'h0000, 16'd0, 20'h00000, 1'b0, 32'h00000000, 1'b1, 1'b1};
      tbl[3] = '{16'h0000, 16'd4, 20'h84215, 1'b1, 32'h00000000, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run(tbl[i], s_tmp);

      // Reset asserted mid-run must clear outputs before the next edge.
      @(negedge clk);
      seed = 16'hBEEF; num_patterns = 16'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", {63'h0, busy}, 64'h1);
      #2 rst = 1'b1;
      #1 chk_reset_vals("async_reset");
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("reset_no_done", 64'(bad), 64'd0);
      rst = 1'b0;

      // Abort after ten patterns: IDLE next cycle, counters frozen.
      @(negedge clk);
      seed = 16'hACE1; num_patterns = 16'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (pat_count !== 16'd10 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 30) chk("abort_wait_timeout", 64'(waited), 64'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_resp_valid", {63'h0, resp_valid}, 64'h0);
      chk("abort_pat_count", {48'h0, pat_count}, 64'd10);
      s_part = model_sig(16'hACE1, 9, 1'b0);
      chk("abort_signature", {32'h0, signature}, {32'h0, s_part});
      s_frozen = signature;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (done !== 1'b0 || signature !== s_frozen || pat_count !== 16'd10) bad++;
      end
      chk("abort_frozen_no_done", 64'(bad), 64'd0);

      v = '{16'hACE1, 16'd100, 20'h0, 1'b0, 32'h0, 1'b0, 1'b0};
      run(v, s_a);
      run(v, s_b);
      chk("repeat_signature", {32'h0, s_b}, {32'h0, s_a});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bist_lane_array.md
Name: bist_lane_array

Overview:
- Parametrised, self-testing successor to the team's 4-input/5-output combinational lane cell.
- Replicates the lane function across LANES channels.
- Drives the lanes from an internal Fibonacci LFSR pattern generator and compacts their registered responses into a Galois MISR signature.
- Controlled by a start/done/abort handshake; sits under the test controller as a built-in self-test engine.

Parameters:
- LANES, 4, number of lane-function instances.
- LFSR_W, 16, pattern LFSR width; must be >= 4*LANES.
- LFSR_TAPS, 16'hB400, LFSR feedback tap mask.
- MISR_W, 32, signature width; must be >= 5*LANES.
- MISR_TAPS, 32'h04C11DB7, MISR Galois polynomial.
- CNT_W, 16, pattern-count width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel a run in RUN/DRAIN.
- seed  in  LFSR_W  LFSR start value.
- num_patterns  in  CNT_W  number of patterns to apply.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse.
- signature  out  MISR_W  MISR contents.
- resp  out  5*LANES  registered lane responses.
- resp_valid  out  1  resp holds a new response this cycle.
- pat_count  out  CNT_W  patterns applied so far.

Behaviour:
- Reset (async): state IDLE; LFSR=1; signature=0; resp=0; resp_valid=0; pat_count=0; busy=0; done=0.
- Lane function. Lane i takes pattern[4i+3:4i]={d,c,b,a} and produces resp[5i+4:5i]={y4,y3,y2,y1,y0}:
  - y0=a|d
  - y1=c&d&~a
  - y2=a|c
  - y3=b
  - y4=~d
- Pattern is lfsr[4*LANES-1:0].
- LFSR step: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
- Seed 0 is loaded as 1 (the all-zero lock-up state is never entered).
- MISR step, applied whenever resp_valid=1: misr <= (misr<<1) ^ (misr[MISR_W-1] ? MISR_TAPS : 0) ^ zero_extend(resp).
- IDLE:
  - start=1 at edge: lfsr<=seed (0 loaded as 1), signature<=0, pat_count<=0.
  - Next state is RUN if num_patterns!=0, else DONE.
- RUN, each edge:
  - resp<=f(pattern); resp_valid<=1; lfsr steps; pat_count++.
  - When pat_count reaches num_patterns, next state is DRAIN.
- DRAIN:
  - MISR absorbs the final response; resp_valid<=0.
  - Next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start at edge 0 → done high between edges N+1 and N+2 for N>=1. For N=0, done is high between edges 1 and 2.
- Signature and pat_count hold after DONE until the next start.
- abort in RUN/DRAIN: next state IDLE; no done pulse; resp_valid<=0; signature and pat_count freeze at their partial values.
- abort has priority over pattern completion.
- start is ignored outside IDLE. start and abort together in IDLE: start wins (abort is a no-op in IDLE).
- num_patterns and seed are sampled only at start; later changes have no effect on the current run.
- pat_count saturates at num_patterns; no counter wrap occurs because the run ends there.
- Reset mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Shared package bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - lane widths LANE_IN_W=4, LANE_OUT_W=5;
  - default polynomial constants.
- One sub-module, bist_lane_cell: a purely combinational 4-in/5-out lane function, instantiated LANES times via generate.
- The LFSR, MISR, counter and FSM live in the top module.

Test Plan:
1. Reset, then hold rst high mid-RUN → all outputs return to reset values asynchronously (before the next edge); no done pulse.
2. Lane function, defaults, seed=16'h000D, num_patterns=1 → resp[4:0]=5'b00101 with resp_valid=1 one cycle after RUN entry.
3. Defaults, seed=16'h1000, num_patterns=1 → resp=20'hAC210; done pulses two cycles after start; signature=32'h000AC210; pat_count=1.
4. num_patterns=0, start → no resp_valid; busy never high; done pulses once; signature=0.
5. seed=0, num_patterns=4 → first pattern is 16'h0001 (lane0 resp 5'b10101, lanes1–3 5'b10000); run completes with pat_count=4.
6. num_patterns=100, abort on cycle 10 of RUN → IDLE next cycle; no done pulse; pat_count=10. A second start with the same seed and N=100 gives a signature matching a software model, and a repeat run gives the identical signature.
